// File: rtl/md_host_link_if.sv
// Link between the host-side driver and the molecular-dynamics compute core.
// The driver (master) streams positions and holds the run request; the core
// (slave) reports completion and streams forces back.
interface md_host_link_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic [WORD_W-1:0] md_position;
  logic              md_pos_valid;
  logic              md_start;
  logic              md_done;
  logic [WORD_W-1:0] md_force;
  logic              md_force_valid;

  modport master (
    output md_position,
    output md_pos_valid,
    output md_start,
    input  md_done,
    input  md_force,
    input  md_force_valid
  );

  modport slave (
    input  md_position,
    input  md_pos_valid,
    input  md_start,
    output md_done,
    output md_force,
    output md_force_valid
  );

endinterface

// File: rtl/md_host_link.sv
// Host-side driver for the MD compute core: buffers one frame of positions,
// streams them to the core, starts it, then captures the force stream into a
// host-readable buffer.
module md_host_link #(
  parameter int unsigned N_ATOMS = 640,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              frame_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  md_host_link_if.master    md
);

  localparam int unsigned      Depth   = 3 * N_ATOMS;
  localparam int unsigned      IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [ADDR_W-1:0] DepthA  = ADDR_W'(Depth);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(Depth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StLoad,
    StRun,
    StUnload,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pos_cnt_q, pos_cnt_d;
  logic [ADDR_W-1:0] frc_cnt_q, frc_cnt_d;
  logic              pos_rd_en;
  logic              frc_wr_en;
  logic              md_pos_valid_q;
  logic [WORD_W-1:0] md_position_q;
  logic [WORD_W-1:0] rd_data_q;

  // Storage is deliberately left out of reset so it keeps the last frame.
  logic [WORD_W-1:0] pos_mem [Depth];
  logic [WORD_W-1:0] frc_mem [Depth];

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pos_cnt_q <= '0;
      frc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_cnt_q <= pos_cnt_d;
      frc_cnt_q <= frc_cnt_d;
    end
  end

  // Next-state logic: sequence prefetch, load, run, unload and finish.
  always_comb begin
    state_d   = state_q;
    pos_cnt_d = pos_cnt_q;
    frc_cnt_d = frc_cnt_q;
    pos_rd_en = 1'b0;
    frc_wr_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        pos_cnt_d = '0;
        frc_cnt_d = '0;
        if (go) state_d = StPrefetch;
      end
      StPrefetch: begin
        pos_rd_en = 1'b1;
        pos_cnt_d = pos_cnt_q + ADDR_W'(1);
        state_d   = StLoad;
      end
      StLoad: begin
        // Word k is presented the cycle after its read, so the counter runs
        // one ahead of the word on md_position.
        if (pos_cnt_q == DepthA) begin
          state_d = StRun;
        end else begin
          pos_rd_en = 1'b1;
          pos_cnt_d = pos_cnt_q + ADDR_W'(1);
        end
      end
      StRun: begin
        frc_cnt_d = '0;
        if (md.md_done) state_d = StUnload;
      end
      StUnload: begin
        if (md.md_force_valid) begin
          frc_wr_en = 1'b1;
          frc_cnt_d = frc_cnt_q + ADDR_W'(1);
          if (frc_cnt_q == LastIdx) state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Position read port doubles as the md_position output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_pos_valid_q <= 1'b0;
      md_position_q  <= '0;
    end else begin
      md_pos_valid_q <= pos_rd_en;
      if (pos_rd_en) md_position_q <= pos_mem[pos_cnt_q[IdxW-1:0]];
    end
  end

  // Host writes into the position buffer, frozen while a frame is in flight.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (wr_addr < DepthA)) pos_mem[wr_addr[IdxW-1:0]] <= wr_data;
  end

  // Captured force words.
  always_ff @(posedge clk) begin
    if (frc_wr_en) frc_mem[frc_cnt_q[IdxW-1:0]] <= md.md_force;
  end

  // Host read of the force buffer; out-of-range addresses read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_addr < DepthA) begin
      rd_data_q <= frc_mem[rd_addr[IdxW-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign busy            = (state_q != StIdle);
  assign frame_done      = (state_q == StFinish);
  assign rd_data         = rd_data_q;
  assign md.md_start     = (state_q == StRun);
  assign md.md_position  = md_position_q;
  assign md.md_pos_valid = md_pos_valid_q;

endmodule
